// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit computer: opcodes and control-word layout.
package cpu_pkg;

  // Opcodes (ir[7:4])
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_LDB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_STA = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hA;
  localparam logic [3:0] OP_TAZ = 4'hB;
  localparam logic [3:0] OP_TZA = 4'hC;
  localparam logic [3:0] OP_NP1 = 4'hD;
  localparam logic [3:0] OP_NP2 = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control-word bit indices. HLT and END are internal to the sequencer.
  localparam int CW_AI  = 0;
  localparam int CW_AO  = 1;
  localparam int CW_BI  = 2;
  localparam int CW_BO  = 3;
  localparam int CW_ZI  = 4;
  localparam int CW_ZO  = 5;
  localparam int CW_II  = 6;
  localparam int CW_IO  = 7;
  localparam int CW_CO  = 8;
  localparam int CW_CE  = 9;
  localparam int CW_J   = 10;
  localparam int CW_EO  = 11;
  localparam int CW_SU  = 12;
  localparam int CW_FI  = 13;
  localparam int CW_MI  = 14;
  localparam int CW_RI  = 15;
  localparam int CW_RO  = 16;
  localparam int CW_OI  = 17;
  localparam int CW_HLT = 18;
  localparam int CW_END = 19;

  localparam int CW_W = 20;

  typedef logic [CW_W-1:0] cw_t;

  // Single-bit masks for building microcode entries.
  localparam cw_t M_AI  = cw_t'(1) << CW_AI;
  localparam cw_t M_AO  = cw_t'(1) << CW_AO;
  localparam cw_t M_BI  = cw_t'(1) << CW_BI;
  localparam cw_t M_ZI  = cw_t'(1) << CW_ZI;
  localparam cw_t M_ZO  = cw_t'(1) << CW_ZO;
  localparam cw_t M_II  = cw_t'(1) << CW_II;
  localparam cw_t M_CO  = cw_t'(1) << CW_CO;
  localparam cw_t M_CE  = cw_t'(1) << CW_CE;
  localparam cw_t M_J   = cw_t'(1) << CW_J;
  localparam cw_t M_EO  = cw_t'(1) << CW_EO;
  localparam cw_t M_SU  = cw_t'(1) << CW_SU;
  localparam cw_t M_FI  = cw_t'(1) << CW_FI;
  localparam cw_t M_MI  = cw_t'(1) << CW_MI;
  localparam cw_t M_RI  = cw_t'(1) << CW_RI;
  localparam cw_t M_RO  = cw_t'(1) << CW_RO;
  localparam cw_t M_OI  = cw_t'(1) << CW_OI;
  localparam cw_t M_HLT = cw_t'(1) << CW_HLT;
  localparam cw_t M_END = cw_t'(1) << CW_END;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: {opcode, step, flags} -> control word.
// The END bit marks the last step of an instruction; HLT requests the halt.
module microcode_rom
  import cpu_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic [2:0] step_i,
  input  logic       flag_c_i,
  input  logic       flag_z_i,
  output cw_t        cw_o
);

  logic taken;

  // Decode one control word; illegal steps 5..7 return to T0 with nothing asserted.
  always_comb begin
    cw_o  = '0;
    taken = (opcode_i == OP_JC) ? flag_c_i : flag_z_i;
    case (step_i)
      3'd0: cw_o = M_CO | M_MI;
      3'd1: begin
        cw_o = M_RO | M_II | M_CE;
        if (opcode_i inside {OP_NOP, OP_NP1, OP_NP2}) cw_o = cw_o | M_END;
      end
      3'd2: begin
        case (opcode_i)
          OP_LDI, OP_LDA, OP_LDB,
          OP_STA, OP_JMP:        cw_o = M_CO | M_MI;
          OP_ADD:                cw_o = M_EO | M_AI | M_FI | M_END;
          OP_SUB:                cw_o = M_EO | M_AI | M_FI | M_SU | M_END;
          // Branch decision is made here only; a not-taken branch skips its operand.
          OP_JC, OP_JZ:          cw_o = taken ? (M_CO | M_MI) : (M_CE | M_END);
          OP_OUT:                cw_o = M_AO | M_OI | M_END;
          OP_TAZ:                cw_o = M_AO | M_ZI | M_END;
          OP_TZA:                cw_o = M_ZO | M_AI | M_END;
          OP_HLT:                cw_o = M_HLT | M_END;
          default:               cw_o = M_END;
        endcase
      end
      3'd3: begin
        case (opcode_i)
          OP_LDI:                cw_o = M_RO | M_AI | M_CE | M_END;
          OP_LDA, OP_LDB, OP_STA: cw_o = M_RO | M_MI | M_CE;
          // Reaching T3 on a branch means it was taken at T2; flags are ignored now.
          OP_JMP, OP_JC, OP_JZ:  cw_o = M_RO | M_J | M_END;
          default:               cw_o = M_END;
        endcase
      end
      3'd4: begin
        case (opcode_i)
          OP_LDA:                cw_o = M_RO | M_AI | M_END;
          OP_LDB:                cw_o = M_RO | M_BI | M_END;
          OP_STA:                cw_o = M_AO | M_RI | M_END;
          default:               cw_o = M_END;
        endcase
      end
      default: cw_o = M_END;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Microcoded sequencer: step counter and halt flag, with the control word
// decoded from the microcode ROM and forced to zero during reset or halt.
module control_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ir,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic       c_ai,
  output logic       c_ao,
  output logic       c_bi,
  output logic       c_bo,
  output logic       c_zi,
  output logic       c_zo,
  output logic       c_ii,
  output logic       c_io,
  output logic       c_co,
  output logic       c_ce,
  output logic       c_j,
  output logic       c_eo,
  output logic       c_su,
  output logic       c_fi,
  output logic       c_mi,
  output logic       c_ri,
  output logic       c_ro,
  output logic       c_oi,
  output logic [2:0] step,
  output logic       halted
);

  logic [2:0] step_q, step_d;
  logic       halted_q, halted_d;
  cw_t        rom_cw;
  cw_t        cw;
  logic       cw_unused;

  microcode_rom u_rom (
    .opcode_i (ir[7:4]),
    .step_i   (step_q),
    .flag_c_i (flag_c),
    .flag_z_i (flag_z),
    .cw_o     (rom_cw)
  );

  // Next state: advance or wrap on END; once halted nothing moves until reset.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      step_d   = rom_cw[CW_END] ? 3'd0 : step_q + 3'd1;
      halted_d = rom_cw[CW_HLT];
    end
  end

  // State register with synchronous reset priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Output gating: no control line may fire while in reset or halted.
  always_comb begin
    cw = rom_cw;
    if (reset || halted_q) cw = '0;
  end

  assign c_ai = cw[CW_AI];
  assign c_ao = cw[CW_AO];
  assign c_bi = cw[CW_BI];
  assign c_bo = cw[CW_BO];
  assign c_zi = cw[CW_ZI];
  assign c_zo = cw[CW_ZO];
  assign c_ii = cw[CW_II];
  assign c_io = 1'b0;  // reserved bus driver, never enabled
  assign c_co = cw[CW_CO];
  assign c_ce = cw[CW_CE];
  assign c_j  = cw[CW_J];
  assign c_eo = cw[CW_EO];
  assign c_su = cw[CW_SU];
  assign c_fi = cw[CW_FI];
  assign c_mi = cw[CW_MI];
  assign c_ri = cw[CW_RI];
  assign c_ro = cw[CW_RO];
  assign c_oi = cw[CW_OI];

  assign step   = step_q;
  assign halted = halted_q;

  // Operand nibble and sequencer-internal bits have no output.
  assign cw_unused = ^{ir[3:0], cw[CW_IO], cw[CW_HLT], cw[CW_END]};

  // Shared bus: at most one driver enabled per cycle.
  a_bus_exclusive : assert property (@(posedge clk) disable iff (reset)
    $onehot0({c_ao, c_bo, c_zo, c_io, c_co, c_eo, c_ro}));

endmodule

// File: doc/control_unit.md
# control_unit

Microcoded sequencer for the 8-bit computer. It drives every control line that the bus-attached blocks consume: register load/output enables, program-counter increment and jump, ALU output and subtract, memory-address/RAM strobes, the flag latch and the output register. It is the counterpart to the datapath, reading the instruction register and ALU flags and generating one control word per clock. It sits between regI/flags and all datapath enables. Only one `*o` enable drives the shared bus in any cycle.

## Interface
- No parameters. Opcode and control-bit constants live in the shared package.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- ir  in  8  instruction register contents (regI output); opcode = ir[7:4], ir[3:0] ignored.
- flag_c, flag_z  in  1 each  latched ALU carry/zero.
- c_ai, c_ao, c_bi, c_bo, c_zi, c_zo, c_ii, c_io  out  1 each  register load/output enables.
- c_co, c_ce, c_j  out  1 each  PC output, increment, load-from-bus.
- c_eo, c_su, c_fi  out  1 each  ALU to bus, subtract, latch flags.
- c_mi, c_ri, c_ro, c_oi  out  1 each  MAR load, RAM write, RAM to bus, output-register load.
- step  out  3  current microstep T0..T7 (debug/verification).
- halted  out  1  HLT executed; sequencer frozen.

## Operation
- 3-bit step counter plus halted flag are the only state. The control word is a combinational decode of {opcode, step, flag_c, flag_z}, gated by halted and reset.
- Fetch (all opcodes): T0 co mi. T1 ro ii ce.
- Execute, from T2. The final listed step returns step to T0.
  - 0 NOP: ends at T1.
  - 1 LDI: T2 co mi; T3 ro ai ce.
  - 2 LDA: T2 co mi; T3 ro mi ce; T4 ro ai.
  - 3 LDB: as LDA with bi instead of ai.
  - 4 ADD: T2 eo ai fi.
  - 5 SUB: T2 eo ai fi su.
  - 6 STA: T2 co mi; T3 ro mi ce; T4 ao ri.
  - 7 JMP: T2 co mi; T3 ro j.
  - 8 JC: if flag_c at T2, behaves as JMP; otherwise T2 ce (skips operand) and ends.
  - 9 JZ: as JC using flag_z.
  - A OUT: T2 ao oi.
  - B TAZ: T2 ao zi.
  - C TZA: T2 zo ai.
  - D, E: NOP.
  - F HLT: T2 sets halted; no other control.
- JC/JZ sample the flags at T2 only. A taken branch holds its path through T3 even if the flags change.
- c_io is never asserted (reserved); it is tied 0.

## Timing
- Reset: step = 0, halted = 0. While reset is high, every control output is forced to 0.
- First rising edge after reset deasserts: step goes 0 to 1. T0 controls are visible during the first cycle with reset low.
- Control outputs are valid for the whole cycle of their step. Destinations capture them at the next rising edge.
- The IR is loaded at the end of T1, so decode at T2 uses the new opcode.
- Cycle counts including fetch:
  - NOP/D/E: 2.
  - ADD/SUB/OUT/TAZ/TZA/HLT: 3.
  - JC/JZ not taken: 3.
  - LDI/JMP/taken branch: 4.
  - LDA/LDB/STA: 5.
- Step never exceeds 4. Reaching 5..7 is illegal: the decode returns step to T0 with all controls 0.
- Halted: the clock edge ending HLT's T2 sets halted and step = 0. From then on all controls are 0 and step is frozen until reset.
- Reset mid-instruction has priority on the same edge: the next cycle starts at T0 with halted = 0.
- Invariant (checked by assertion): at most one of ao, bo, zo, io, co, eo, ro is high in any cycle.

## Structure
- Shared package cpu_pkg:
  - opcode localparams (OP_NOP..OP_HLT);
  - control-word bit indices;
  - control-word width constant.
- Sub-module microcode_rom: purely combinational {opcode, step, flags} → control word. It holds the `end` bit that resets step.
- control_unit itself holds only the step counter, halted, and output gating.

## Test plan
- Reset for 2 cycles, then release, ir = 0x00: T0 co+mi, T1 ro+ii+ce, then back to T0. Step sequence 0,1,0,1.
- ir = 0x20 (LDA): steps 0..4 with exactly the listed enables. Bus-exclusivity assertion never fires.
- ir = 0x50 (SUB): T2 asserts eo, ai, fi, su together for exactly one cycle. Step then returns to 0.
- ir = 0x90 (JZ):
  - flag_z = 1: T3 asserts ro+j, 4 cycles total.
  - flag_z = 0: T2 asserts ce only, 3 cycles total.
  - Flag toggled at T3 of the taken case: no effect.
- ir = 0xF0 (HLT): halted = 1 after T2. All outputs 0 and step = 0 for 20 cycles. Reset then clears halted.
- Reset asserted at T3 of STA (0x60): the next cycle shows step = 0 with T0 controls and no ri pulse.
